// File: rtl/capture_ctrl_if.sv
// FIFO-side bundle of the capture controller: write/read strobes, reset and status.
interface capture_ctrl_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] fifo_din;
    logic          fifo_wren;
    logic          fifo_rden;
    logic          fifo_reset;
    logic          fifo_full;
    logic          fifo_empty;

    modport master (
        output fifo_din, fifo_wren, fifo_rden, fifo_reset,
        input  fifo_full, fifo_empty
    );

    modport slave (
        input  fifo_din, fifo_wren, fifo_rden, fifo_reset,
        output fifo_full, fifo_empty
    );
endinterface

// File: rtl/capture_ctrl.sv
// Triggered ADC capture sequencer: pre-trigger fill, level-crossing/forced trigger,
// post-trigger fill, then host readout from an external FIFO.
module capture_ctrl #(
    parameter logic [15:0] PRE_COUNT = 16'd256,
    parameter int unsigned DW        = 8
) (
    input  logic                  adc_dco,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic [DW-1:0]         sample,
    input  logic [DW-1:0]         trig_level,
    input  logic                  trig_rising,
    input  logic                  force_trig,
    input  logic                  arm,
    input  logic [15:0]           post_count,
    input  logic                  pic_ready,
    capture_ctrl_if.master        fifo,
    output logic [2:0]            state,
    output logic                  trig_pulse
);
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        PREFILL  = 3'd2,
        ARMED    = 3'd3,
        POST     = 3'd4,
        WAITHOST = 3'd5,
        READOUT  = 3'd6
    } state_t;

    state_t               st;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        post_lat;
    logic signed [DW-1:0] prev;
    logic                 prev_vld;
    logic                 force_q;

    logic                 accept_c;
    logic [CW-1:0]        cnt_inc_c;
    logic [CW-1:0]        cnt_nxt_c;
    logic signed [DW-1:0] smp_s;
    logic signed [DW-1:0] lvl_s;
    logic                 cross_c;
    logic                 trig_c;

    assign state = st;

    // Samples are only written while filling; a full FIFO drops the sample.
    assign accept_c  = sample_valid && !fifo.fifo_full &&
                       (st == PREFILL || st == ARMED || st == POST);
    assign cnt_inc_c = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    assign cnt_nxt_c = accept_c ? cnt_inc_c : cnt;

    assign smp_s   = sample;
    assign lvl_s   = trig_level;
    assign cross_c = trig_rising ? (prev <  lvl_s && smp_s >= lvl_s)
                                 : (prev >= lvl_s && smp_s <  lvl_s);
    assign trig_c  = (sample_valid && prev_vld && cross_c) || (force_trig && !force_q);

    always_ff @(posedge adc_dco) begin
        if (!rst_n) begin
            st              <= IDLE;
            cnt             <= '0;
            post_lat        <= '0;
            prev            <= '0;
            prev_vld        <= 1'b0;
            force_q         <= 1'b0;
            fifo.fifo_din   <= '0;
            fifo.fifo_wren  <= 1'b0;
            fifo.fifo_rden  <= 1'b0;
            fifo.fifo_reset <= 1'b1;
            trig_pulse      <= 1'b0;
        end else begin
            fifo.fifo_wren  <= 1'b0;
            fifo.fifo_reset <= 1'b0;
            trig_pulse      <= 1'b0;
            force_q         <= force_trig;

            if (accept_c) begin
                fifo.fifo_din  <= sample;
                fifo.fifo_wren <= 1'b1;
            end

            unique case (st)
                IDLE: begin
                    if (arm) begin
                        st              <= CLEAR;
                        fifo.fifo_reset <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= '0;
                    st  <= PREFILL;
                end
                PREFILL: begin
                    cnt <= cnt_nxt_c;
                    if (cnt_nxt_c >= PRE_COUNT) begin
                        st       <= ARMED;
                        prev_vld <= 1'b0;
                    end
                end
                ARMED: begin
                    // A full FIFO while waiting restarts the pre-trigger window.
                    if (fifo.fifo_full) begin
                        fifo.fifo_reset <= 1'b1;
                        cnt             <= '0;
                        st              <= PREFILL;
                    end else begin
                        if (sample_valid) begin
                            prev     <= smp_s;
                            prev_vld <= 1'b1;
                        end
                        if (trig_c) begin
                            trig_pulse <= 1'b1;
                            post_lat   <= post_count;
                            cnt        <= '0;
                            st         <= POST;
                        end
                    end
                end
                POST: begin
                    if (fifo.fifo_full) begin
                        st <= WAITHOST;
                    end else begin
                        cnt <= cnt_nxt_c;
                        if (cnt_nxt_c >= post_lat) begin
                            st <= WAITHOST;
                        end
                    end
                end
                WAITHOST: begin
                    if (pic_ready) begin
                        st             <= READOUT;
                        fifo.fifo_rden <= 1'b1;
                    end
                end
                READOUT: begin
                    if (fifo.fifo_empty || !pic_ready) begin
                        fifo.fifo_rden <= 1'b0;
                        st             <= IDLE;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios plus randomized captures against a
// sample-stream model (which samples land in the FIFO and where the trigger falls).
module tb_capture_ctrl;
    localparam int unsigned DW  = 8;
    localparam logic [15:0] PRE = 16'd4;

    logic          adc_dco;
    logic          rst_n;
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic [DW-1:0] trig_level;
    logic          trig_rising;
    logic          force_trig;
    logic          arm;
    logic [15:0]   post_count;
    logic          pic_ready;
    logic [2:0]    state;
    logic          trig_pulse;

    capture_ctrl_if #(.DW(DW)) fifo ();

    capture_ctrl #(.PRE_COUNT(PRE), .DW(DW)) dut (
        .adc_dco      (adc_dco),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .force_trig   (force_trig),
        .arm          (arm),
        .post_count   (post_count),
        .pic_ready    (pic_ready),
        .fifo         (fifo),
        .state        (state),
        .trig_pulse   (trig_pulse)
    );

    int checks = 0;
    int errors = 0;

    initial adc_dco = 1'b0;
    always #5 adc_dco = ~adc_dco;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at state %0d", state);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge adc_dco);
        #1;
    endtask

    task automatic start_capture();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic prefill(input int last_val);
        for (int k = 0; k < int'(PRE); k++) begin
            sample_valid = 1'b1;
            sample = (k == int'(PRE) - 1) ? 8'(last_val) : 8'($urandom);
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (fifo.fifo_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", fifo.fifo_wren); end
        checks++; if (fifo.fifo_rden !== 1'b0) begin errors++; $display("FAIL reset_rden got %b exp 0", fifo.fifo_rden); end
        checks++; if (trig_pulse !== 1'b0) begin errors++; $display("FAIL reset_trig got %b exp 0", trig_pulse); end
        checks++; if (fifo.fifo_din !== 8'd0) begin errors++; $display("FAIL reset_din got %0h exp 0", fifo.fifo_din); end
        checks++; if (fifo.fifo_reset !== 1'b1) begin errors++; $display("FAIL reset_fifo_reset got %b exp 1", fifo.fifo_reset); end
        rst_n = 1'b1;
        tick();
        checks++; if (fifo.fifo_reset !== 1'b0) begin errors++; $display("FAIL release_fifo_reset got %b exp 0", fifo.fifo_reset); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL release_state got %0d exp 0", state); end
    endtask

    task automatic test_prefill();
        int n_wr;
        logic [7:0] v;
        n_wr = 0;
        arm = 1'b1;
        tick();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL clear_state got %0d exp 1", state); end
        checks++; if (fifo.fifo_reset !== 1'b1) begin errors++; $display("FAIL clear_reset got %b exp 1", fifo.fifo_reset); end
        arm = 1'b0;
        tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL prefill_state got %0d exp 2", state); end
        checks++; if (fifo.fifo_reset !== 1'b0) begin errors++; $display("FAIL clear_reset_len got %b exp 0", fifo.fifo_reset); end
        for (int k = 0; k < 4; k++) begin
            v = 8'($urandom);
            sample_valid = 1'b1;
            sample = v;
            tick();
            sample_valid = 1'b0;
            if (fifo.fifo_wren === 1'b1) n_wr++;
            checks++; if (fifo.fifo_wren !== 1'b1 || fifo.fifo_din !== v) begin
                errors++; $display("FAIL prefill_write got wren=%b din=%0h exp wren=1 din=%0h", fifo.fifo_wren, fifo.fifo_din, v);
            end
            tick();
            if (fifo.fifo_wren === 1'b1) n_wr++;
            checks++; if (fifo.fifo_wren !== 1'b0) begin errors++; $display("FAIL prefill_wren_len got %b exp 0", fifo.fifo_wren); end
        end
        checks++; if (n_wr != 4) begin errors++; $display("FAIL prefill_count got %0d exp 4", n_wr); end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL prefill_armed got %0d exp 3", state); end
    endtask

    task automatic test_rising();
        int vals [4] = '{3, 5, -5, 3};
        logic exp_tp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int n_wr;
        trig_rising = 1'b1;
        trig_level  = 8'd0;
        post_count  = 16'd2;
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1;
            sample = 8'(vals[k]);
            tick();
            checks++; if (trig_pulse !== exp_tp[k]) begin errors++; $display("FAIL rise_trig[%0d] got %b exp %b", k, trig_pulse, exp_tp[k]); end
        end
        sample_valid = 1'b0;
        n_wr = (fifo.fifo_wren === 1'b1) ? 1 : 0;
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL rise_post got %0d exp 4", state); end
        post_count = 16'd7;
        tick();
        checks++; if (trig_pulse !== 1'b0) begin errors++; $display("FAIL rise_pulse_len got %b exp 0", trig_pulse); end
        for (int k = 0; k < 3; k++) begin
            sample_valid = 1'b1;
            sample = 8'($urandom);
            tick();
            sample_valid = 1'b0;
            if (fifo.fifo_wren === 1'b1) n_wr++;
            if (k == 1) begin
                checks++; if (state !== 3'd5) begin errors++; $display("FAIL post_done got %0d exp 5", state); end
            end
            tick();
        end
        checks++; if (n_wr != 3) begin errors++; $display("FAIL post_writes got %0d exp 3", n_wr); end
        pic_ready = 1'b1;
        tick();
        checks++; if (state !== 3'd6 || fifo.fifo_rden !== 1'b1) begin
            errors++; $display("FAIL readout_enter got st=%0d rden=%b exp st=6 rden=1", state, fifo.fifo_rden);
        end
        tick();
        checks++; if (fifo.fifo_rden !== 1'b1) begin errors++; $display("FAIL readout_hold got %b exp 1", fifo.fifo_rden); end
        fifo.fifo_empty = 1'b1;
        tick();
        checks++; if (state !== 3'd0 || fifo.fifo_rden !== 1'b0) begin
            errors++; $display("FAIL readout_empty got st=%0d rden=%b exp st=0 rden=0", state, fifo.fifo_rden);
        end
        pic_ready = 1'b0;
        fifo.fifo_empty = 1'b0;
    endtask

    task automatic test_falling();
        int vals [3] = '{9, 20, -128};
        logic exp_tp [3] = '{1'b0, 1'b0, 1'b1};
        trig_rising = 1'b0;
        trig_level  = 8'd10;
        post_count  = 16'd0;
        start_capture();
        prefill(20);
        tick();
        for (int k = 0; k < 3; k++) begin
            sample_valid = 1'b1;
            sample = 8'(vals[k]);
            tick();
            checks++; if (trig_pulse !== exp_tp[k]) begin errors++; $display("FAIL fall_trig[%0d] got %b exp %b", k, trig_pulse, exp_tp[k]); end
        end
        sample_valid = 1'b0;
        checks++; if (fifo.fifo_din !== 8'h80 || fifo.fifo_wren !== 1'b1) begin
            errors++; $display("FAIL fall_trig_write got din=%0h wren=%b exp din=80 wren=1", fifo.fifo_din, fifo.fifo_wren);
        end
        tick();
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL post_zero got %0d exp 5", state); end
        pic_ready = 1'b1;
        tick();
        checks++; if (state !== 3'd6) begin errors++; $display("FAIL fall_readout got %0d exp 6", state); end
        pic_ready = 1'b0;
        tick();
        checks++; if (state !== 3'd0 || fifo.fifo_rden !== 1'b0) begin
            errors++; $display("FAIL ready_drop got st=%0d rden=%b exp st=0 rden=0", state, fifo.fifo_rden);
        end
    endtask

    task automatic test_full_rearm();
        int n_tp;
        n_tp = 0;
        start_capture();
        for (int k = 0; k < 4; k++) begin
            sample_valid = 1'b1;
            sample = 8'($urandom);
            if (k == 1) force_trig = 1'b1;
            tick();
            if (trig_pulse === 1'b1) n_tp++;
        end
        sample_valid = 1'b0;
        tick();
        if (trig_pulse === 1'b1) n_tp++;
        tick();
        if (trig_pulse === 1'b1) n_tp++;
        checks++; if (n_tp != 0) begin errors++; $display("FAIL force_prefill got %0d pulses exp 0", n_tp); end
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL force_prefill_state got %0d exp 3", state); end
        force_trig = 1'b0;
        tick();
        fifo.fifo_full = 1'b1;
        sample_valid = 1'b1;
        sample = 8'h55;
        tick();
        sample_valid = 1'b0;
        checks++; if (fifo.fifo_reset !== 1'b1 || state !== 3'd2 || fifo.fifo_wren !== 1'b0) begin
            errors++; $display("FAIL full_rearm got rst=%b st=%0d wren=%b exp rst=1 st=2 wren=0", fifo.fifo_reset, state, fifo.fifo_wren);
        end
        fifo.fifo_full = 1'b0;
        tick();
        checks++; if (fifo.fifo_reset !== 1'b0 || state !== 3'd2) begin
            errors++; $display("FAIL full_rearm_len got rst=%b st=%0d exp rst=0 st=2", fifo.fifo_reset, state);
        end
        post_count = 16'd1;
        prefill(0);
        force_trig = 1'b1;
        tick();
        checks++; if (trig_pulse !== 1'b1 || state !== 3'd4) begin
            errors++; $display("FAIL force_armed got tp=%b st=%0d exp tp=1 st=4", trig_pulse, state);
        end
        force_trig = 1'b0;
        fifo.fifo_full = 1'b1;
        tick();
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL post_full got %0d exp 5", state); end
        fifo.fifo_full = 1'b0;
        fifo.fifo_empty = 1'b1;
        pic_ready = 1'b1;
        tick();
        tick();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL full_idle got %0d exp 0", state); end
        pic_ready = 1'b0;
        fifo.fifo_empty = 1'b0;
    endtask

    task automatic test_reset_readout();
        start_capture();
        post_count = 16'd0;
        prefill(0);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        tick();
        pic_ready = 1'b1;
        tick();
        checks++; if (state !== 3'd6 || fifo.fifo_rden !== 1'b1) begin
            errors++; $display("FAIL rst_pre_readout got st=%0d rden=%b exp st=6 rden=1", state, fifo.fifo_rden);
        end
        rst_n = 1'b0;
        tick();
        checks++; if (state !== 3'd0 || fifo.fifo_rden !== 1'b0 || fifo.fifo_wren !== 1'b0) begin
            errors++; $display("FAIL rst_readout got st=%0d rden=%b wren=%b exp 0 0 0", state, fifo.fifo_rden, fifo.fifo_wren);
        end
        rst_n = 1'b1;
        pic_ready = 1'b0;
        tick();
        checks++; if (fifo.fifo_reset !== 1'b0 || state !== 3'd0) begin
            errors++; $display("FAIL rst_release got rst=%b st=%0d exp 0 0", fifo.fifo_reset, state);
        end
    endtask

    // Model: first sample after the pre-trigger window is never compared; the
    // first later crossing triggers, and exactly pc more samples follow it.
    function automatic bit crosses(input int p, input int c, input int lvl, input bit rising);
        if (rising) return (p < lvl) && (c >= lvl);
        return (p >= lvl) && (c < lvl);
    endfunction

    task automatic test_random();
        int s[$];
        logic [7:0] wq[$];
        int lvl, pc, n, ti, tp_cnt, exp_n;
        bit rising;
        logic [7:0] tp_din;
        for (int it = 0; it < 6; it++) begin
            s.delete();
            wq.delete();
            tp_cnt = 0;
            tp_din = 8'd0;
            lvl    = int'($urandom_range(200)) - 100;
            rising = 1'($urandom_range(1));
            pc     = int'($urandom_range(4, 1));
            n      = int'($urandom_range(12, 6));
            for (int k = 0; k < n; k++) s.push_back(int'($urandom_range(255)) - 128);
            if (rising) begin s.push_back(lvl - 1); s.push_back(lvl); end
            else        begin s.push_back(lvl);     s.push_back(lvl - 1); end
            for (int k = 0; k < pc + 3; k++) s.push_back(int'($urandom_range(255)) - 128);
            ti = -1;
            for (int i = int'(PRE) + 1; i < s.size(); i++)
                if (ti < 0 && crosses(s[i-1], s[i], lvl, rising)) ti = i;
            exp_n = ti + pc + 1;

            trig_level  = 8'(lvl);
            trig_rising = rising;
            post_count  = 16'(pc);
            start_capture();
            for (int k = 0; k < s.size(); k++) begin
                int gap;
                gap = int'($urandom_range(2));
                sample_valid = 1'b1;
                sample = 8'(s[k]);
                for (int g = 0; g <= gap + ((k == s.size() - 1) ? 2 : 0); g++) begin
                    tick();
                    sample_valid = 1'b0;
                    if (fifo.fifo_wren === 1'b1) wq.push_back(fifo.fifo_din);
                    if (trig_pulse === 1'b1) begin tp_cnt++; tp_din = fifo.fifo_din; end
                end
            end
            checks++; if (wq.size() != exp_n) begin errors++; $display("FAIL rnd%0d_nwr got %0d exp %0d", it, wq.size(), exp_n); end
            for (int k = 0; k < wq.size() && k < exp_n; k++) begin
                checks++; if (wq[k] !== 8'(s[k])) begin errors++; $display("FAIL rnd%0d_data[%0d] got %0h exp %0h", it, k, wq[k], 8'(s[k])); end
            end
            checks++; if (tp_cnt != 1) begin errors++; $display("FAIL rnd%0d_npulse got %0d exp 1", it, tp_cnt); end
            checks++; if (tp_din !== 8'(s[ti])) begin errors++; $display("FAIL rnd%0d_trig_smp got %0h exp %0h", it, tp_din, 8'(s[ti])); end
            checks++; if (state !== 3'd5) begin errors++; $display("FAIL rnd%0d_wait got %0d exp 5", it, state); end
            pic_ready = 1'b1;
            tick();
            checks++; if (fifo.fifo_rden !== 1'b1) begin errors++; $display("FAIL rnd%0d_rden got %b exp 1", it, fifo.fifo_rden); end
            fifo.fifo_empty = 1'b1;
            tick();
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL rnd%0d_idle got %0d exp 0", it, state); end
            pic_ready = 1'b0;
            fifo.fifo_empty = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        sample_valid    = 1'b0;
        sample          = '0;
        trig_level      = '0;
        trig_rising     = 1'b1;
        force_trig      = 1'b0;
        arm             = 1'b0;
        post_count      = 16'd0;
        pic_ready       = 1'b0;
        fifo.fifo_full  = 1'b0;
        fifo.fifo_empty = 1'b0;
        test_reset();
        test_prefill();
        test_rising();
        test_falling();
        test_full_rearm();
        test_reset_readout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter PRE_COUNT, default 16'd256: number of pre-trigger samples written before arming.
REQ-002 SHALL have parameter DW, default 8: sample width.
REQ-003 SHALL have port adc_dco  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe per decimated sample.
REQ-006 SHALL have port sample  input  DW  signed ADC sample, valid with sample_valid.
REQ-007 SHALL have port trig_level  input  DW  signed trigger threshold.
REQ-008 SHALL have port trig_rising  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-009 SHALL have port force_trig  input  1  manual trigger, level, already synchronous.
REQ-010 SHALL have port arm  input  1  start-capture request, level.
REQ-011 SHALL have port post_count  input  16  post-trigger sample count.
REQ-012 SHALL have port pic_ready  input  1  host ready to receive.
REQ-013 SHALL have ports fifo_full and fifo_empty  input  1 each  FIFO status.
REQ-014 SHALL have port fifo_din  output  DW  registered sample to FIFO.
REQ-015 SHALL have ports fifo_wren, fifo_rden, fifo_reset  output  1 each  FIFO controls.
REQ-016 SHALL have port state  output  3  current FSM state encoding.
REQ-017 SHALL have port trig_pulse  output  1  one-cycle pulse on accepted trigger.

Function
REQ-018 SHALL implement FSM states IDLE=0, CLEAR=1, PREFILL=2, ARMED=3, POST=4, WAITHOST=5, READOUT=6.
REQ-019 SHALL, in IDLE with arm=1, go to CLEAR.
REQ-020 SHALL, in CLEAR, assert fifo_reset for exactly one cycle, zero the sample counter, then go to PREFILL.
REQ-021 SHALL, in PREFILL, ARMED and POST, on each sample_valid with fifo_full=0, register sample into fifo_din and pulse fifo_wren on the next cycle (latency 1).
REQ-022 SHALL drop a sample with no fifo_wren when sample_valid coincides with fifo_full=1.
REQ-023 SHALL go from PREFILL to ARMED once PRE_COUNT samples are written; PRE_COUNT=0 means go next cycle.
REQ-024 SHALL detect a rising trigger as prev<trig_level and cur>=trig_level (signed); falling as prev>=trig_level and cur<trig_level; prev/cur are consecutive valid samples.
REQ-025 SHALL invalidate prev on ARMED entry; the first sample in ARMED never triggers.
REQ-026 SHALL treat a 0->1 edge of force_trig as a trigger in ARMED only; it is ignored, not latched, elsewhere.
REQ-027 SHALL, on trigger in ARMED, pulse trig_pulse, latch post_count, write the triggering sample, and go to POST.
REQ-028 SHALL, in ARMED with fifo_full=1, pulse fifo_reset for one cycle and return to PREFILL (re-arm, no trigger lost mid-write).
REQ-029 SHALL, in POST, count written samples; at count==latched post_count go to WAITHOST; a latched value of 0 means go next cycle.
REQ-030 SHALL, in POST with fifo_full=1, go to WAITHOST early.
REQ-031 SHALL, in WAITHOST with pic_ready=1, go to READOUT.
REQ-032 SHALL hold fifo_rden=1 in READOUT; when fifo_empty=1 or pic_ready=0, deassert fifo_rden the next cycle and go to IDLE.
REQ-033 SHALL ignore arm outside IDLE and sample_valid outside PREFILL/ARMED/POST.
REQ-034 SHALL use 16-bit counters that saturate, never wrap.

Reset
REQ-035 SHALL, with rst_n=0 at a clock edge, set state=IDLE and fifo_wren=0, fifo_rden=0, trig_pulse=0, fifo_din=0, counters=0, prev invalid, and fifo_reset=1; fifo_reset returns to 0 on the first cycle after release.
REQ-036 SHALL abort any state immediately when reset is asserted mid-capture, with no further FIFO strobes.

Verification
REQ-037 SHALL cover: PRE_COUNT=4, arm, 4 samples -> exactly 4 fifo_wren pulses, each 1 cycle after sample_valid; state=ARMED.
REQ-038 SHALL cover: trig_rising=1, level=0, samples -5,3 in ARMED -> trig_pulse on sample 3, state=POST; samples 3,5 -> no trigger.
REQ-039 SHALL cover: trig_rising=0, level=10, samples 20,-128 -> trigger (signed compare); first ARMED sample 9 after entry -> no trigger.
REQ-040 SHALL cover: post_count=2 -> 3 writes in total from the trigger, then WAITHOST; pic_ready=1 -> fifo_rden high until fifo_empty, then IDLE.
REQ-041 SHALL cover: fifo_full in ARMED -> one-cycle fifo_reset, state=PREFILL; force_trig edge in PREFILL -> no trigger.
REQ-042 SHALL cover: rst_n=0 during READOUT -> fifo_rden=0 and state=IDLE on the next edge.
